// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: after each frame update, decides whether a new obstacle is due,
// picks its type from the RNG under speed and duplicate limits, and arms one free slot.
module obstacle_scheduler #(
  parameter int unsigned SLOTS           = 3,
  parameter int unsigned SETTLE          = 4,
  parameter int unsigned MAX_RETRY       = 8,
  parameter int unsigned MAX_DUP         = 2,
  parameter int unsigned SPEED_SCALE     = 1024,
  parameter int unsigned MIN_SPEED_SMALL = 0,
  parameter int unsigned MIN_SPEED_LARGE = 0,
  parameter int unsigned MIN_SPEED_PTERO = (SPEED_SCALE * 17) / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  update,
  input  logic                  crash,
  input  logic [14:0]           speed,
  input  logic [10:0]           rng_data,
  input  logic [SLOTS-1:0]      slot_remove,
  input  logic [SLOTS*11-1:0]   slot_x_pos,
  input  logic [SLOTS*10-1:0]   slot_width,
  input  logic [SLOTS*11-1:0]   slot_gap,
  output logic [SLOTS-1:0]      slot_start,
  output logic [1:0]            typ,
  output logic [SLOTS-1:0]      active
);

  localparam int unsigned SEL_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {TY_NONE, TY_SMALL, TY_LARGE, TY_PTERO} type_t;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_UPD, S_SETTLE, S_CHECK, S_PICK, S_ARMED, S_CRASHED
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  type_t              typ_q, typ_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q;
  logic [SLOTS-1:0]   active_q, active_d;
  type_t              hist_q [MAX_DUP];
  logic               commit;

  logic [10:0]        last_x;
  logic [9:0]         last_w;
  logic [10:0]        last_g;
  logic signed [12:0] reach;
  logic               due;
  logic               free_found;
  logic [SEL_W-1:0]   free_idx;
  type_t              cand;
  logic [14:0]        min_spd;
  logic               dup_all;
  logic               reject;

  always_comb begin
    last_x = '0;
    last_w = '0;
    last_g = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (last_q == SEL_W'(i)) begin
        last_x = slot_x_pos[i*11 +: 11];
        last_w = slot_width[i*10 +: 10];
        last_g = slot_gap[i*11 +: 11];
      end
    end
  end

  // Trailing edge of the newest obstacle; x is signed, width and gap are magnitudes.
  assign reach = {{2{last_x[10]}}, last_x} + {3'b000, last_w} + {2'b00, last_g};
  assign due   = (active_q == '0) | ~active_q[last_q] | (reach < 13'sd640);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    cand = type_t'(2'(rng_data % 11'd3) + 2'd1);
    case (cand)
      TY_SMALL: min_spd = 15'(MIN_SPEED_SMALL);
      TY_LARGE: min_spd = 15'(MIN_SPEED_LARGE);
      default:  min_spd = 15'(MIN_SPEED_PTERO);
    endcase
    dup_all = 1'b1;
    for (int unsigned i = 0; i < MAX_DUP; i++) begin
      if (hist_q[i] != cand) dup_all = 1'b0;
    end
    reject = (speed < min_spd) | dup_all;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    typ_d   = typ_q;
    sel_d   = sel_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_WAIT_UPD;
      S_WAIT_UPD: if (update) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                  end
      S_SETTLE:   if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_CHECK;
                  else cnt_d = cnt_q + 1'b1;
      S_CHECK:    if (due && free_found) begin
                    state_d = S_PICK;
                    sel_d   = free_idx;
                  end else begin
                    state_d = S_WAIT_UPD;
                  end
      S_PICK:     if (retry_q == RTY_W'(MAX_RETRY)) begin
                    typ_d   = TY_SMALL;
                    retry_d = '0;
                    state_d = S_ARMED;
                  end else if (reject) begin
                    retry_d = retry_q + 1'b1;
                  end else begin
                    typ_d   = cand;
                    retry_d = '0;
                    state_d = S_ARMED;
                  end
      S_ARMED:    if (update) begin
                    commit  = 1'b1;
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                  end
      default:    state_d = S_CRASHED;
    endcase
    // Disable and crash override everything decided above, including a pending commit.
    if (!enable && state_q != S_CRASHED) begin
      state_d = S_IDLE;
      typ_d   = typ_q;
      commit  = 1'b0;
    end
    if (crash) begin
      state_d = S_CRASHED;
      typ_d   = typ_q;
      commit  = 1'b0;
    end
  end

  always_comb begin
    active_d = active_q;
    if (state_q != S_CRASHED && !crash) begin
      active_d = active_q & ~slot_remove;
      if (commit) active_d[sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      typ_q    <= TY_NONE;
      sel_q    <= '0;
      last_q   <= '0;
      active_q <= '0;
      for (int unsigned i = 0; i < MAX_DUP; i++) hist_q[i] <= TY_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      typ_q    <= typ_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      if (commit) begin
        last_q    <= sel_q;
        retry_q   <= '0;
        hist_q[0] <= typ_q;
        for (int unsigned i = 1; i < MAX_DUP; i++) hist_q[i] <= hist_q[i-1];
      end
    end
  end

  always_comb begin
    slot_start = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      slot_start[i] = (state_q == S_ARMED) && (sel_q == SEL_W'(i));
    end
  end

  assign typ    = typ_q;
  assign active = active_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: directed frames plus randomized frames checked against a
// frame-level model of spawn decisions, type picks, slot ownership and history.
module tb_obstacle_scheduler;
  localparam int SLOTS = 3;
  localparam int PTERO_MIN = 8704;

  logic                clk = 1'b0;
  logic                rst, enable, update, crash;
  logic [14:0]         speed;
  logic [10:0]         rng_data;
  logic [SLOTS-1:0]    slot_remove;
  logic [SLOTS*11-1:0] slot_x_pos;
  logic [SLOTS*10-1:0] slot_width;
  logic [SLOTS*11-1:0] slot_gap;
  logic [SLOTS-1:0]    slot_start;
  logic [1:0]          typ;
  logic [SLOTS-1:0]    active;

  obstacle_scheduler #(.SLOTS(SLOTS), .SETTLE(4), .MAX_RETRY(8), .MAX_DUP(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .update(update), .crash(crash),
    .speed(speed), .rng_data(rng_data), .slot_remove(slot_remove),
    .slot_x_pos(slot_x_pos), .slot_width(slot_width), .slot_gap(slot_gap),
    .slot_start(slot_start), .typ(typ), .active(active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level reference state
  logic [2:0] m_active;
  int m_hist0, m_hist1, m_last, m_typ, m_psel, m_ptyp;
  bit m_pend, m_crashed;
  int sx[3], sw[3], sg[3];
  int rng_seq[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_slots();
    for (int i = 0; i < 3; i++) begin
      slot_x_pos[i*11 +: 11] = 11'(sx[i]);
      slot_width[i*10 +: 10] = 10'(sw[i]);
      slot_gap[i*11 +: 11]   = 11'(sg[i]);
    end
  endtask

  task automatic model_reset();
    m_active = '0; m_hist0 = 0; m_hist1 = 0; m_last = 0; m_typ = 0;
    m_pend = 0; m_crashed = 0; m_psel = 0; m_ptyp = 0;
  endtask

  function automatic bit m_due();
    if (m_active == 0) return 1;
    if (!m_active[m_last]) return 1;
    return (sx[m_last] + sw[m_last] + sg[m_last]) < 640;
  endfunction

  // Pick model: returns chosen type and the PICK cycle index at which it is accepted.
  task automatic m_pick(output int t, output int k);
    int rej = 0;
    for (k = 0; k < 16; k++) begin
      int c;
      if (rej == 8) begin t = 1; return; end
      c = rng_seq[k] % 3 + 1;
      if ((int'(speed) < ((c == 3) ? PTERO_MIN : 0)) || (m_hist0 == c && m_hist1 == c)) rej++;
      else begin t = c; return; end
    end
    t = 1;
  endtask

  task automatic do_frame();
    bit spawn = 0;
    int sel = 0, ptyp = 0, k = 0;
    update = 1'b1; rng_data = 11'($urandom);
    @(negedge clk);
    update = 1'b0;
    if (!m_crashed && m_pend) begin
      m_hist1 = m_hist0; m_hist0 = m_ptyp;
      m_active[m_psel] = 1'b1; m_last = m_psel; m_pend = 0;
    end
    chk("active_after_update", {29'b0, active}, {29'b0, m_active});
    if (!m_crashed && m_due()) begin
      for (int i = 2; i >= 0; i--) if (!m_active[i]) begin sel = i; spawn = 1; end
      if (spawn) m_pick(ptyp, k);
    end
    for (int c = 1; c <= 5; c++) begin
      rng_data = 11'($urandom);
      @(negedge clk);
    end
    chk("start_before_pick", {29'b0, slot_start}, 32'd0);
    for (int j = 0; j < 16; j++) begin
      rng_data = 11'(rng_seq[j]);
      @(negedge clk);
      chk("slot_start", {29'b0, slot_start}, (spawn && j >= k) ? (32'd1 << sel) : 32'd0);
    end
    if (spawn) begin m_typ = ptyp; m_pend = 1; m_psel = sel; m_ptyp = ptyp; end
    chk("typ", {30'b0, typ}, 32'(m_typ));
  endtask

  task automatic remove(input logic [2:0] mask);
    slot_remove = mask;
    @(negedge clk);
    slot_remove = '0;
    if (!m_crashed) m_active = m_active & ~mask;
    chk("active_after_remove", {29'b0, active}, {29'b0, m_active});
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    @(negedge clk);
    chk("start_enable_low", {29'b0, slot_start}, 32'd0);
    m_pend = 0;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_seq(input int v);
    for (int j = 0; j < 16; j++) rng_seq[j] = v;
  endtask

  task automatic rand_seq();
    for (int j = 0; j < 16; j++) rng_seq[j] = int'($urandom_range(0, 2047));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; update = 1'b0; crash = 1'b0;
    speed = 15'd1024; rng_data = '0; slot_remove = '0;
    for (int i = 0; i < 3; i++) begin sx[i] = 0; sw[i] = 20; sg[i] = 100; end
    apply_slots();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_start", {29'b0, slot_start}, 32'd0);
    chk("reset_typ", {30'b0, typ}, 32'd0);
    chk("reset_active", {29'b0, active}, 32'd0);
    enable = 1'b1;
    @(negedge clk);

    // All slots idle: slot 0 armed with SMALL.
    fill_seq(0); do_frame();
    // Last obstacle reaches 647: not due.
    sx[0] = 500; sw[0] = 17; sg[0] = 130; apply_slots();
    rand_seq(); do_frame();
    // Reach 627 with PTERO forced at low speed: fallback to SMALL after 8 rejections.
    sx[0] = 480; apply_slots();
    fill_seq(2); do_frame();
    // History SMALL,SMALL: SMALL rejected, LARGE accepted.
    sx[1] = 0; apply_slots();
    fill_seq(1); rng_seq[0] = 0; do_frame();
    // All slots owned and due: nothing armed.
    sx[2] = 0; apply_slots();
    rand_seq(); do_frame();
    // Freeing slot 1 makes it the next target.
    remove(3'b010);
    rand_seq(); do_frame();

    for (int f = 0; f < 40; f++) begin
      speed = 15'($urandom_range(0, 16000));
      for (int i = 0; i < 3; i++) begin
        sx[i] = int'($urandom_range(0, 1000)) - 300;
        sw[i] = int'($urandom_range(10, 60));
        sg[i] = int'($urandom_range(100, 400));
      end
      apply_slots();
      rand_seq();
      if ($urandom_range(0, 2) == 0) remove(3'($urandom_range(1, 7)));
      if ($urandom_range(0, 7) == 0) drop_enable();
      do_frame();
    end

    // Crash while ARMED: start drops, nothing spawns, state frozen until reset.
    remove(3'b111);
    rand_seq(); do_frame();
    crash = 1'b1;
    @(negedge clk);
    crash = 1'b0;
    m_crashed = 1; m_pend = 0;
    chk("start_after_crash", {29'b0, slot_start}, 32'd0);
    for (int f = 0; f < 100; f++) begin
      rand_seq();
      if (f == 50) remove(3'b111);
      do_frame();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_start", {29'b0, slot_start}, 32'd0);
    chk("rst_typ", {30'b0, typ}, 32'd0);
    chk("rst_active", {29'b0, active}, 32'd0);
    @(negedge clk);
    speed = 15'd9000;
    fill_seq(2); do_frame();
    rand_seq(); do_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
